dmem_store_buffer: RTL and testbench

Data-memory front end sitting directly downstream of the pipelined core's Memory stage: it consumes the core's M-stage memory request (address, store data, write/read strobes) and returns load data. It also drives a slower word-wide backing-memory bus through a req/ack handshake. Stores are posted into a small FIFO and drained in order. Loads are forwarded from the buffer on an address hit; otherwise they wait for the buffer to empty and go to the bus, stalling the core through StallMemM.

---
 rtl/arm_mem_pkg.sv | 20 ++
 rtl/stbuf_fifo.sv | 76 +++++++
 rtl/dmem_store_buffer.sv | 132 +++++++++++++
 tb/tb_dmem_store_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory store buffer:
// FSM state enum, buffer entry layout and default sizes.
package arm_mem_pkg;

  localparam int STBUF_AW    = 32;
  localparam int STBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ST_BUSY,
    LD_BUSY,
    LD_DONE
  } state_t;

  typedef struct packed {
    logic [STBUF_AW-3:0] addr;
    logic [31:0]         data;
  } stbuf_entry_t;

endpackage

// File: rtl/stbuf_fifo.sv
// Store-buffer entry storage: circular FIFO with head/tail/count.
// Ports: clk, reset, push/wr_entry (enqueue), pop (dequeue head),
//   full, empty, count, head, head_next (entry behind head).
// With STBUF_FWD_EN: lkp_addr in, hit/hit_data out (youngest match).
module stbuf_fifo
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  stbuf_entry_t            wr_entry,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output stbuf_entry_t            head,
`ifdef STBUF_FWD_EN
  input  logic [STBUF_AW-3:0]     lkp_addr,
  output logic                    hit,
  output logic [31:0]             hit_data,
`endif
  output stbuf_entry_t            head_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  stbuf_entry_t    mem [DEPTH];
  logic [PW-1:0]   hptr;
  logic [PW-1:0]   tptr;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      hptr  <= '0;
      tptr  <= '0;
      count <= '0;
    end else begin
      if (push) tptr <= tptr + PW'(1);
      if (pop)  hptr <= hptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tptr] <= wr_entry;
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[hptr];
  assign head_next = mem[hptr + PW'(1)];

`ifdef STBUF_FWD_EN
  // Scan oldest to youngest; later matches override earlier ones
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = hptr + PW'(i);
      if (CW'(i) < count && mem[idx].addr == lkp_addr) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory front end: posted store FIFO drained over a req/ack bus,
// loads forwarded from the buffer or fetched after the buffer drains.
// Core side: MemWriteM/MemReadM/ALUOutM/WriteDataM in,
//   ReadDataM/StallMemM out.
// Bus side: BusReq/BusWe/BusAddr/BusWData out (registered),
//   BusRData/BusAck in.
// Macro STBUF_FWD_EN enables store-to-load forwarding.
module dmem_store_buffer
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH,
  parameter int AW    = STBUF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          StallMemM,
  output logic          BusReq,
  output logic          BusWe,
  output logic [AW-1:0] BusAddr,
  output logic [31:0]   BusWData,
  input  logic [31:0]   BusRData,
  input  logic          BusAck
);

  localparam int CW = $clog2(DEPTH+1);

  state_t          state;
  logic [31:0]     ld_data;
  stbuf_entry_t    wr_entry;
  stbuf_entry_t    head;
  stbuf_entry_t    head_next;
  stbuf_entry_t    nxt;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            stay;
  logic            hit;
  logic [31:0]     hit_data;
  logic            unused_lsb;

  assign unused_lsb = ^ALUOutM[1:0];
  assign wr_entry   = '{addr: ALUOutM[AW-1:2], data: WriteDataM};

  stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_entry  (wr_entry),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head),
`ifdef STBUF_FWD_EN
    .lkp_addr  (ALUOutM[AW-1:2]),
    .hit       (hit),
    .hit_data  (hit_data),
`endif
    .head_next (head_next)
  );

`ifndef STBUF_FWD_EN
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign StallMemM = (MemWriteM & full)
                   | (MemReadM & ~hit & (state != LD_DONE));
  assign push      = MemWriteM & ~StallMemM;
  assign pop       = (state == ST_BUSY) & BusAck;
  assign ReadDataM = (state == LD_DONE) ? ld_data : hit_data;

  // On a drain ack with one entry left, a same-cycle push becomes
  // the next head and has not reached storage yet.
  assign stay = (count > CW'(1)) | push;
  assign nxt  = (count == CW'(1)) ? wr_entry : head_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      BusReq   <= 1'b0;
      BusWe    <= 1'b0;
      BusAddr  <= '0;
      BusWData <= '0;
      ld_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state    <= ST_BUSY;
            BusReq   <= 1'b1;
            BusWe    <= 1'b1;
            BusAddr  <= {head.addr, 2'b00};
            BusWData <= head.data;
          end else if (MemReadM && !hit) begin
            state   <= LD_BUSY;
            BusReq  <= 1'b1;
            BusWe   <= 1'b0;
            BusAddr <= {ALUOutM[AW-1:2], 2'b00};
          end
        end
        ST_BUSY: begin
          if (BusAck) begin
            if (stay) begin
              BusAddr  <= {nxt.addr, 2'b00};
              BusWData <= nxt.data;
            end else begin
              state  <= IDLE;
              BusReq <= 1'b0;
            end
          end
        end
        LD_BUSY: begin
          if (BusAck) begin
            state   <= LD_DONE;
            BusReq  <= 1'b0;
            ld_data <= BusRData;
          end
        end
        LD_DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: bus transaction and
// load-data scoreboards against a simple bus slave model.
module tb_dmem_store_buffer;

`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int LIM = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [31:0] BusRData;
  logic        BusAck;

  always #5 clk = ~clk;

  dmem_store_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMemM  (StallMemM),
    .BusReq     (BusReq),
    .BusWe      (BusWe),
    .BusAddr    (BusAddr),
    .BusWData   (BusWData),
    .BusRData   (BusRData),
    .BusAck     (BusAck)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_ld[$];
  logic [31:0] arch[logic [31:0]];
  logic [31:0] bmem[logic [31:0]];

  int bus_wait  = 0;
  bit hold_ack  = 0;
  bit ack_pulse = 0;
  int wcnt      = 0;

  function automatic logic [31:0] wa(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rd_arch(input logic [31:0] a);
    return arch.exists(wa(a)) ? arch[wa(a)] : 32'h0;
  endfunction

  // bus slave: decides ack 2 time units after each rising edge
  initial begin
    BusAck   = 1'b0;
    BusRData = '0;
    forever begin
      @(posedge clk);
      #2;
      if (BusReq === 1'b1 && ack_pulse) begin
        BusAck    = 1'b1;
        ack_pulse = 0;
      end else if (BusReq !== 1'b1 || hold_ack) begin
        BusAck = 1'b0;
        wcnt   = 0;
      end else if (wcnt >= bus_wait) begin
        BusAck = 1'b1;
        wcnt   = 0;
      end else begin
        BusAck = 1'b0;
        wcnt++;
      end
      BusRData = bmem.exists(BusAddr) ? bmem[BusAddr] : 32'h0;
    end
  end

  // bus monitor: a transaction completes in a cycle with req & ack
  always @(negedge clk) begin
    bus_t e;
    if (!reset && BusReq === 1'b1 && BusAck === 1'b1) begin
      if (exp_bus.size() == 0) begin
        chk("bus_extra", 64'(exp_bus.size()), 64'd1);
      end else begin
        e = exp_bus.pop_front();
        chk("bus_we", 64'(BusWe), 64'(e.we));
        chk("bus_addr", 64'(BusAddr), 64'(e.addr));
        if (e.we) begin
          chk("bus_wdata", 64'(BusWData), 64'(e.data));
          bmem[BusAddr] = BusWData;
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d,
                          output int stalls);
    bus_t e;
    e.we   = 1'b1;
    e.addr = wa(a);
    e.data = d;
    exp_bus.push_back(e);
    arch[wa(a)] = d;
    MemWriteM  = 1'b1;
    ALUOutM    = a;
    WriteDataM = d;
    stalls     = 0;
    for (int k = 0; k < LIM; k++) begin
      @(negedge clk);
      if (!StallMemM) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    chk("st_bound", 64'(stalls >= LIM), 64'd0);
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a,
                         input bit rd,
                         output int stalls);
    bus_t e;
    if (rd) begin
      e.we   = 1'b0;
      e.addr = wa(a);
      e.data = '0;
      exp_bus.push_back(e);
    end
    exp_ld.push_back(rd_arch(a));
    MemReadM = 1'b1;
    ALUOutM  = a;
    stalls   = 0;
    for (int k = 0; k < LIM; k++) begin
      @(negedge clk);
      if (!StallMemM) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    chk("ld_bound", 64'(stalls >= LIM), 64'd0);
    chk("ld_data", 64'(ReadDataM), 64'(exp_ld.pop_front()));
    @(posedge clk);
    #1;
    MemReadM = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    for (int k = 0; k < LIM; k++) begin
      @(negedge clk);
      if (!BusReq && exp_bus.size() == 0) break;
      n++;
    end
    chk("idle_bound", 64'(n >= LIM), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int n;
    bus_t e;
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    MemReadM   = 1'b0;
    ALUOutM    = '0;
    WriteDataM = '0;
    bmem[32'h200] = 32'h12345678;
    arch[32'h200] = 32'h12345678;
    bmem[32'h300] = 32'h0BADF00D;
    arch[32'h300] = 32'h0BADF00D;
    bmem[32'h500] = 32'hCAFE0001;
    arch[32'h500] = 32'hCAFE0001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busreq", 64'(BusReq), 64'd0);
    chk("rst_buswe", 64'(BusWe), 64'd0);
    chk("rst_busaddr", 64'(BusAddr), 64'd0);
    chk("rst_buswdata", 64'(BusWData), 64'd0);
    chk("rst_stall", 64'(StallMemM), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // load miss, empty buffer, zero-wait ack
    do_load(32'h200, 1'b1, s);
    chk("miss_stall", 64'(s), 64'd2);
    wait_idle();

    // two bus wait cycles add two stall cycles
    bus_wait = 2;
    do_load(32'h200, 1'b1, s);
    chk("miss_wait_stall", 64'(s), 64'd4);
    bus_wait = 0;
    wait_idle();

    // store then load same word
    do_store(32'h100, 32'hDEADBEEF, s);
    chk("st_nostall", 64'(s), 64'd0);
    do_load(32'h100, !FWD, s);
    chk("fwd_nostall", 64'(s == 0), 64'(FWD));
    wait_idle();

    // youngest of two matching stores wins
    do_store(32'h40, 32'h1, s);
    do_store(32'h40, 32'h2, s);
    do_load(32'h42, !FWD, s);
    wait_idle();

    // fill the buffer with the bus stalled
    hold_ack = 1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), s);
      chk("fill_nostall", 64'(s), 64'd0);
    end
    e.we   = 1'b1;
    e.addr = 32'h1010;
    e.data = 32'hA4;
    exp_bus.push_back(e);
    arch[32'h1010] = 32'hA4;
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h1010;
    WriteDataM = 32'hA4;
    ack_pulse  = 1;
    @(negedge clk);
    chk("full_stall", 64'(StallMemM), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_enq", 64'(StallMemM), 64'd0);
    @(posedge clk);
    #1;
    e.addr = 32'h1014;
    e.data = 32'hA5;
    exp_bus.push_back(e);
    arch[32'h1014] = 32'hA5;
    ALUOutM    = 32'h1014;
    WriteDataM = 32'hA5;
    @(negedge clk);
    chk("refull_stall", 64'(StallMemM), 64'd1);
    hold_ack = 0;
    n = 0;
    for (int k = 0; k < LIM; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!StallMemM) break;
      n++;
    end
    chk("refull_bound", 64'(n >= LIM), 64'd0);
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    wait_idle();

    // load miss behind two pending stores: W, W, R
    bus_wait = 2;
    do_store(32'h2000, 32'h11, s);
    do_store(32'h2004, 32'h22, s);
    do_load(32'h500, 1'b1, s);
    chk("ld_behind_st", 64'(s > 4), 64'd1);
    bus_wait = 0;
    wait_idle();

    // reset while a drain is outstanding
    hold_ack   = 1;
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h300;
    WriteDataM = 32'hAAAA5555;
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    n = 0;
    for (int k = 0; k < LIM; k++) begin
      @(negedge clk);
      if (BusReq) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("rst_setup", 64'(BusReq), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busreq", 64'(BusReq), 64'd0);
    chk("mid_rst_busaddr", 64'(BusAddr), 64'd0);
    hold_ack = 0;
    @(posedge clk);
    #1;
    do_load(32'h300, 1'b1, s);
    chk("post_rst_stall", 64'(s), 64'd2);
    wait_idle();

    chk("bus_left", 64'(exp_bus.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
